// File: rtl/irq_edge_capture.sv
// Destination-domain interrupt edge capture: glitch filter, rising-edge strobe,
// sticky pending flag with acknowledge, and a saturating event counter.
module irq_edge_capture #(
  parameter int unsigned FILTER_CYCLES = 3,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             d_synced,
  input  logic             enable,
  input  logic             ack,
  input  logic             clear_cnt,
  output logic             level_filtered,
  output logic             irq_pulse,
  output logic             irq_pending,
  output logic [CNT_W-1:0] event_count,
  output logic             overflow
);

  localparam int unsigned     QW        = $clog2(FILTER_CYCLES + 1);
  localparam logic [QW-1:0]   QUAL_LAST = QW'(FILTER_CYCLES);
  localparam logic [QW-1:0]   QCNT_ONE  = QW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_QUAL_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_QUAL_LOW  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [QW-1:0]     qcnt_q, qcnt_d;
  logic              level_q, level_d;
  logic              pulse_q, pulse_d;
  logic              pending_q, pending_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              rise_s;

  // Next-state logic for the filter FSM and the event bookkeeping.
  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    pending_d = pending_q;
    count_d   = count_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_LOW: begin
        if (d_synced) begin
          if (FILTER_CYCLES == 32'd1) begin
            state_d = S_HIGH;
            qcnt_d  = '0;
          end else begin
            state_d = S_QUAL_HIGH;
            qcnt_d  = QCNT_ONE;
          end
        end else begin
          qcnt_d = '0;
        end
      end
      S_QUAL_HIGH: begin
        if (!d_synced) begin
          state_d = S_LOW;
          qcnt_d  = '0;
        end else if (qcnt_q + QCNT_ONE == QUAL_LAST) begin
          state_d = S_HIGH;
          qcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_q + QCNT_ONE;
        end
      end
      S_HIGH: begin
        if (!d_synced) begin
          if (FILTER_CYCLES == 32'd1) begin
            state_d = S_LOW;
            qcnt_d  = '0;
          end else begin
            state_d = S_QUAL_LOW;
            qcnt_d  = QCNT_ONE;
          end
        end else begin
          qcnt_d = '0;
        end
      end
      S_QUAL_LOW: begin
        if (d_synced) begin
          state_d = S_HIGH;
          qcnt_d  = '0;
        end else if (qcnt_q + QCNT_ONE == QUAL_LAST) begin
          state_d = S_LOW;
          qcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_q + QCNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        qcnt_d  = '0;
      end
    endcase

    level_d = (state_d == S_HIGH) || (state_d == S_QUAL_LOW);
    // The event comes from this cycle's transition so the strobe lines up with level_d.
    rise_s  = (state_d == S_HIGH) && ((state_q == S_LOW) || (state_q == S_QUAL_HIGH));
    pulse_d = rise_s && enable;

    // A registered pulse beats a same-cycle ack so no interrupt is dropped.
    if (pulse_q) begin
      pending_d = 1'b1;
    end else if (ack) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    if (clear_cnt) begin
      count_d = pulse_q ? CNT_ONE : '0;
      ovf_d   = 1'b0;
    end else if (pulse_q) begin
      if (count_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end else begin
      count_d = count_q;
      ovf_d   = ovf_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_LOW;
      qcnt_q    <= '0;
      level_q   <= 1'b0;
      pulse_q   <= 1'b0;
      pending_q <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  assign level_filtered = level_q;
  assign irq_pulse      = pulse_q;
  assign irq_pending    = pending_q;
  assign event_count    = count_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_irq_edge_capture.sv
// Scoreboard bench for irq_edge_capture: a FILTER_CYCLES=3 and a FILTER_CYCLES=1
// instance share stimulus; a behavioural model queues expected outputs per cycle.
module tb_irq_edge_capture;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic d_synced = 1'b0;
  logic enable = 1'b1;
  logic ack = 1'b0;
  logic clear_cnt = 1'b0;

  logic       lvl3, pls3, pnd3, ovf3;
  logic [3:0] cnt3;
  logic       lvl1, pls1, pnd1, ovf1;
  logic [3:0] cnt1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic       lvl;
    logic       pls;
    logic       pnd;
    logic [3:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t q3[$];
  exp_t q1[$];

  // model state, index 0 -> FILTER_CYCLES=3, index 1 -> FILTER_CYCLES=1
  logic m_lvl[2];
  int   m_run[2];
  logic m_pls[2];
  logic m_pnd[2];
  int   m_cnt[2];
  logic m_ovf[2];

  always #5 clk = ~clk;

  irq_edge_capture #(.FILTER_CYCLES(3), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .d_synced(d_synced), .enable(enable), .ack(ack),
    .clear_cnt(clear_cnt), .level_filtered(lvl3), .irq_pulse(pls3),
    .irq_pending(pnd3), .event_count(cnt3), .overflow(ovf3)
  );

  irq_edge_capture #(.FILTER_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rstn(rstn), .d_synced(d_synced), .enable(enable), .ack(ack),
    .clear_cnt(clear_cnt), .level_filtered(lvl1), .irq_pulse(pls1),
    .irq_pending(pnd1), .event_count(cnt1), .overflow(ovf1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lvl[k] = 1'b0; m_run[k] = 0; m_pls[k] = 1'b0;
      m_pnd[k] = 1'b0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input int fc);
    logic old_pls;
    old_pls = m_pls[k];
    if (old_pls) m_pnd[k] = 1'b1;
    else if (ack) m_pnd[k] = 1'b0;
    if (clear_cnt) begin
      m_cnt[k] = old_pls ? 1 : 0;
      m_ovf[k] = 1'b0;
    end else if (old_pls) begin
      if (m_cnt[k] == 15) m_ovf[k] = 1'b1;
      else m_cnt[k] = m_cnt[k] + 1;
    end
    m_pls[k] = 1'b0;
    if (d_synced != m_lvl[k]) begin
      m_run[k] = m_run[k] + 1;
      if (m_run[k] == fc) begin
        m_lvl[k] = ~m_lvl[k];
        m_run[k] = 0;
        if (m_lvl[k] && enable) m_pls[k] = 1'b1;
      end
    end else begin
      m_run[k] = 0;
    end
  endtask

  task automatic compare(input string pfx, input exp_t e, input logic lvl, input logic pls,
                         input logic pnd, input logic [3:0] cnt, input logic ovf);
    check({pfx, "_level"}, {31'd0, lvl}, {31'd0, e.lvl});
    check({pfx, "_pulse"}, {31'd0, pls}, {31'd0, e.pls});
    check({pfx, "_pending"}, {31'd0, pnd}, {31'd0, e.pnd});
    check({pfx, "_count"}, {28'd0, cnt}, {28'd0, e.cnt});
    check({pfx, "_ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
  endtask

  // Drive one cycle of stimulus, queue the expected response, then check it after the edge.
  task automatic cyc(input logic d, input logic en, input logic a, input logic clr);
    exp_t e;
    d_synced = d; enable = en; ack = a; clear_cnt = clr;
    model_step(0, 3);
    model_step(1, 1);
    e = '{m_lvl[0], m_pls[0], m_pnd[0], 4'(m_cnt[0]), m_ovf[0]};
    q3.push_back(e);
    e = '{m_lvl[1], m_pls[1], m_pnd[1], 4'(m_cnt[1]), m_ovf[1]};
    q1.push_back(e);
    @(posedge clk);
    #1;
    if (q3.size() == 0 || q1.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = q3.pop_front();
      compare("fc3", e, lvl3, pls3, pnd3, cnt3, ovf3);
      e = q1.pop_front();
      compare("fc1", e, lvl1, pls1, pnd1, cnt1, ovf1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fc3"}, {27'd0, lvl3, pls3, pnd3, ovf3, |cnt3}, 32'd0);
    check({tag, "_fc1"}, {27'd0, lvl1, pls1, pnd1, ovf1, |cnt1}, 32'd0);
  endtask

  task automatic pulse_event(input logic en);
    for (int i = 0; i < 3; i++) cyc(1'b1, en, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, en, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rstn = 1'b1;

    // reset while qualifying a rising level, then a clean restart
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("reset_midqual");
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("restart_not_yet", {31'd0, lvl3}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("restart_level", {31'd0, lvl3}, 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);

    // glitch of two cycles on the slow filter
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("glitch_count", {28'd0, cnt3}, 32'd0);

    // qualified edge and a falling edge that must not count
    pulse_event(1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("qual_count", {28'd0, cnt3}, 32'd1);

    // event coincident with ack, then ack alone
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("race_pending", {31'd0, pnd3}, 32'd1);
    check("race_count", {28'd0, cnt3}, 32'd2);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("ack_alone", {31'd0, pnd3}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // saturation, clear, and clear coincident with an event
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 16; n++) pulse_event(1'b1);
    check("sat_count", {28'd0, cnt3}, 32'd15);
    check("sat_ovf", {31'd0, ovf3}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("clr_count", {28'd0, cnt3}, 32'd0);
    check("clr_ovf", {31'd0, ovf3}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_evt_count", {28'd0, cnt3}, 32'd1);
    check("clr_evt_ovf", {31'd0, ovf3}, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);

    // disabled edges still move the filtered level, then re-enable
    for (int i = 0; i < 6; i++) cyc(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0);
    check("dis_count1", {28'd0, cnt1}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("dis_level1", {31'd0, lvl1}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("reen_pulse1", {31'd0, pls1}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("reen_count1", {28'd0, cnt1}, 32'd1);
    pulse_event(1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
